// File: rtl/fu_branch_pipe_if.sv
// Issue/result bundle for fu_branch_pipe: the scheduler holds the master end, the unit the slave end.
// Prediction-check signals exist only when FU_BRANCH_PREDICT_CHECK_EN is defined.
interface fu_branch_pipe_if #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 1,
  parameter int TAG_W   = 4
);
  localparam int CNT_W = $clog2(LATENCY + 1);

  // Issue side
  logic             EN;
  logic             JALR;
  logic [2:0]       cmp_ctrl;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [XLEN-1:0]  imm;
  logic [XLEN-1:0]  PC;
  logic [TAG_W-1:0] tag_in;
  logic             flush;

  // Result side
  logic             finish;
  logic [TAG_W-1:0] tag_out;
  logic             cmp_res;
  logic [XLEN-1:0]  PC_jump;
  logic [XLEN-1:0]  PC_wb;
  logic             misalign;
  logic [CNT_W-1:0] inflight;

`ifdef FU_BRANCH_PREDICT_CHECK_EN
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             mispredict;

  modport master (
    output EN, JALR, cmp_ctrl, rs1_data, rs2_data, imm, PC, tag_in, flush,
           pred_taken, pred_target,
    input  finish, tag_out, cmp_res, PC_jump, PC_wb, misalign, inflight, mispredict
  );
  modport slave (
    input  EN, JALR, cmp_ctrl, rs1_data, rs2_data, imm, PC, tag_in, flush,
           pred_taken, pred_target,
    output finish, tag_out, cmp_res, PC_jump, PC_wb, misalign, inflight, mispredict
  );
`else
  modport master (
    output EN, JALR, cmp_ctrl, rs1_data, rs2_data, imm, PC, tag_in, flush,
    input  finish, tag_out, cmp_res, PC_jump, PC_wb, misalign, inflight
  );
  modport slave (
    input  EN, JALR, cmp_ctrl, rs1_data, rs2_data, imm, PC, tag_in, flush,
    output finish, tag_out, cmp_res, PC_jump, PC_wb, misalign, inflight
  );
`endif
endinterface

// File: rtl/fu_branch_pipe.sv
// Fully pipelined branch/JAL/JALR unit: resolves in stage 0, then shifts results through LATENCY-1 registers.
// Optional prediction check (pred_taken/pred_target -> mispredict) under `FU_BRANCH_PREDICT_CHECK_EN.
module fu_branch_pipe #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 1,
  parameter int TAG_W   = 4
) (
  input  logic           clk,
  input  logic           rst,
  fu_branch_pipe_if.slave bus
);
  localparam int CNT_W = $clog2(LATENCY + 1);

  // Handshake: an op is issued in any cycle with EN=1 and flush=0 (no ready, never stalls);
  // finish is a one-cycle valid with no ready, so the consumer must take the result that cycle.

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             taken;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  link;
    logic             mis;
`ifdef FU_BRANCH_PREDICT_CHECK_EN
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
`endif
  } stage_t;

  logic             accept;
  logic             taken;
  logic [XLEN-1:0]  base;
  logic [XLEN-1:0]  sum;
  logic [XLEN-1:0]  target;
  stage_t           nxt;
  stage_t           stg [LATENCY];
  logic [LATENCY-1:0] vld;
  logic [CNT_W-1:0] cnt;
  logic             fin;
  stage_t           out;

  assign accept = bus.EN & ~bus.flush;

  always_comb begin
    taken = 1'b1;
    case (bus.cmp_ctrl)
      3'b000:  taken = (bus.rs1_data == bus.rs2_data);
      3'b001:  taken = (bus.rs1_data != bus.rs2_data);
      3'b100:  taken = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
      3'b101:  taken = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
      3'b110:  taken = (bus.rs1_data <  bus.rs2_data);
      3'b111:  taken = (bus.rs1_data >= bus.rs2_data);
      default: taken = 1'b1;
    endcase
  end

  assign base   = bus.JALR ? bus.rs1_data : bus.PC;
  assign sum    = base + bus.imm;
  assign target = {sum[XLEN-1:1], 1'b0};

  always_comb begin
    nxt             = '0;
    nxt.tag         = bus.tag_in;
    nxt.taken       = taken;
    nxt.target      = target;
    nxt.link        = bus.PC + XLEN'(4);
    nxt.mis         = taken & target[1];
`ifdef FU_BRANCH_PREDICT_CHECK_EN
    nxt.pred_taken  = bus.pred_taken;
    nxt.pred_target = bus.pred_target;
`endif
  end

  // Valid bits: reset beats flush beats issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (bus.flush) begin
      vld <= '0;
    end else begin
      vld[0] <= bus.EN;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  // Payload needs no reset; it is only observed through the valid bits.
  always_ff @(posedge clk) begin
    if (bus.EN) begin
      stg[0] <= nxt;
    end
    for (int i = 1; i < LATENCY; i++) begin
      stg[i] <= stg[i-1];
    end
  end

  assign fin = vld[LATENCY-1];
  assign out = stg[LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(accept) - CNT_W'(fin);
    end
  end

  assign bus.finish   = fin;
  assign bus.tag_out  = fin ? out.tag    : '0;
  assign bus.cmp_res  = fin ? out.taken  : 1'b0;
  assign bus.PC_jump  = fin ? out.target : '0;
  assign bus.PC_wb    = fin ? out.link   : '0;
  assign bus.misalign = fin ? out.mis    : 1'b0;
  assign bus.inflight = cnt;

`ifdef FU_BRANCH_PREDICT_CHECK_EN
  assign bus.mispredict = fin &
    ((out.taken != out.pred_taken) | (out.taken & (out.target != out.pred_target)));
`endif
endmodule

// File: tb/tb_fu_branch_pipe.sv
// Bench for fu_branch_pipe: LATENCY=1 and LATENCY=3 instances driven identically, checked against a
// cycle-indexed queue model of issued operations.
module tb_fu_branch_pipe;
  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int W     = 74;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        en, jalr, flush;
  logic [2:0]  cmp_ctrl;
  logic [31:0] rs1, rs2, imm, pc;
  logic [3:0]  tag;
`ifdef FU_BRANCH_PREDICT_CHECK_EN
  logic        pt;
  logic [31:0] ptgt;
`endif

  fu_branch_pipe_if #(.XLEN(XLEN), .LATENCY(1), .TAG_W(TAG_W)) b1 ();
  fu_branch_pipe_if #(.XLEN(XLEN), .LATENCY(3), .TAG_W(TAG_W)) b3 ();

  fu_branch_pipe #(.XLEN(XLEN), .LATENCY(1), .TAG_W(TAG_W)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  fu_branch_pipe #(.XLEN(XLEN), .LATENCY(3), .TAG_W(TAG_W)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  assign b1.EN = en;        assign b3.EN = en;
  assign b1.JALR = jalr;    assign b3.JALR = jalr;
  assign b1.cmp_ctrl = cmp_ctrl; assign b3.cmp_ctrl = cmp_ctrl;
  assign b1.rs1_data = rs1; assign b3.rs1_data = rs1;
  assign b1.rs2_data = rs2; assign b3.rs2_data = rs2;
  assign b1.imm = imm;      assign b3.imm = imm;
  assign b1.PC = pc;        assign b3.PC = pc;
  assign b1.tag_in = tag;   assign b3.tag_in = tag;
  assign b1.flush = flush;  assign b3.flush = flush;
`ifdef FU_BRANCH_PREDICT_CHECK_EN
  assign b1.pred_taken = pt;    assign b3.pred_taken = pt;
  assign b1.pred_target = ptgt; assign b3.pred_target = ptgt;
`endif

  // ---------------- reference model ----------------
  // Each accepted op is stored with the cycle index in which it must be finishing.
  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic        taken;
    logic [31:0] target;
    logic [31:0] link;
    logic        mis;
    logic        mp;
  } exp_t;

  exp_t exp_q1[$];
  exp_t exp_q3[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t model_op(int due);
    exp_t e;
    logic [31:0] s;
    e.due = due;
    e.tag = tag;
    case (cmp_ctrl)
      3'd0:    e.taken = (rs1 == rs2);
      3'd1:    e.taken = (rs1 != rs2);
      3'd4:    e.taken = (int'(rs1) <  int'(rs2));
      3'd5:    e.taken = (int'(rs1) >= int'(rs2));
      3'd6:    e.taken = (rs1 <  rs2);
      3'd7:    e.taken = (rs1 >= rs2);
      default: e.taken = 1'b1;
    endcase
    s        = (jalr ? rs1 : pc) + imm;
    e.target = s & 32'hFFFF_FFFE;
    e.link   = pc + 32'd4;
    e.mis    = e.taken & e.target[1];
`ifdef FU_BRANCH_PREDICT_CHECK_EN
    e.mp     = (e.taken != pt) | (e.taken & (e.target != ptgt));
`else
    e.mp     = 1'b0;
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    exp_q1 = exp_q1.find with (item.due >= cyc);
    exp_q3 = exp_q3.find with (item.due >= cyc);
    if (rst || flush) begin
      exp_q1.delete();
      exp_q3.delete();
    end else if (en) begin
      exp_q1.push_back(model_op(cyc));
      exp_q3.push_back(model_op(cyc + 2));
    end
    #1;
  endtask

  function automatic logic [W-1:0] exp_vec(int d);
    logic [W-1:0] v;
    exp_t e;
    int n;
    v = '0;
    n = (d == 0) ? exp_q1.size() : exp_q3.size();
    for (int i = 0; i < n; i++) begin
      e = (d == 0) ? exp_q1[i] : exp_q3[i];
      if (e.due == cyc) v = {1'b1, e.tag, e.taken, e.target, e.link, e.mis, 2'b00, e.mp};
    end
    v[2:1] = n[1:0];
    return v;
  endfunction

  function automatic logic [W-1:0] obs_vec(int d);
    logic mp1, mp3;
`ifdef FU_BRANCH_PREDICT_CHECK_EN
    mp1 = b1.mispredict;
    mp3 = b3.mispredict;
`else
    mp1 = 1'b0;
    mp3 = 1'b0;
`endif
    if (d == 0)
      return {b1.finish, b1.tag_out, b1.cmp_res, b1.PC_jump, b1.PC_wb, b1.misalign, 1'b0, b1.inflight, mp1};
    return {b3.finish, b3.tag_out, b3.cmp_res, b3.PC_jump, b3.PC_wb, b3.misalign, b3.inflight, mp3};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    en = 1'b0; jalr = 1'b0; flush = 1'b0; cmp_ctrl = 3'd0;
    rs1 = '0; rs2 = '0; imm = '0; pc = '0; tag = '0;
`ifdef FU_BRANCH_PREDICT_CHECK_EN
    pt = 1'b0; ptgt = '0;
`endif
  endtask

  task automatic drive_op(input logic j, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic [31:0] p, input logic [3:0] t);
    en = 1'b1; jalr = j; flush = 1'b0; cmp_ctrl = c;
    rs1 = a; rs2 = b; imm = im; pc = p; tag = t;
`ifdef FU_BRANCH_PREDICT_CHECK_EN
    pt = 1'b0; ptgt = '0;
`endif
  endtask

  task automatic drain(input int n);
    set_idle();
    for (int k = 0; k < n; k++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL drain lat%0d cyc%0d got=%h exp=%h", d ? 3 : 1, cyc, obs_vec(d), exp_vec(d));
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    en  = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_vec(d) !== exp_vec(d)) begin
        errors++;
        $display("FAIL reset lat%0d got=%h exp=%h", d ? 3 : 1, obs_vec(d), exp_vec(d));
      end
    end
    rst = 1'b0;
    set_idle();
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_vec(d) !== {W{1'b0}}) begin
        errors++;
        $display("FAIL reset_idle lat%0d got=%h exp=0", d ? 3 : 1, obs_vec(d));
      end
    end
  endtask

  task automatic test_beq();
    drain(4);
    drive_op(1'b0, 3'b000, 32'd5, 32'd5, 32'h20, 32'h100, 4'd7);
    tick();
    checks++;
    if ({b1.finish, b1.cmp_res, b1.PC_jump, b1.PC_wb} !== {1'b1, 1'b1, 32'h120, 32'h104}) begin
      errors++;
      $display("FAIL beq fin/res/jump/wb got=%b %b %h %h exp=1 1 00000120 00000104",
               b1.finish, b1.cmp_res, b1.PC_jump, b1.PC_wb);
    end
    set_idle();
    tick();
    checks++;
    if (obs_vec(0) !== {W{1'b0}}) begin
      errors++;
      $display("FAIL beq_after got=%h exp=0", obs_vec(0));
    end
    drain(3);
  endtask

  task automatic test_jalr();
    drive_op(1'b1, 3'b010, 32'h1003, 32'd0, 32'h4, 32'h200, 4'd2);
    tick();
    checks++;
    if ({b1.cmp_res, b1.PC_jump, b1.misalign, b1.PC_wb} !== {1'b1, 32'h1006, 1'b1, 32'h204}) begin
      errors++;
      $display("FAIL jalr res/jump/mis/wb got=%b %h %b %h exp=1 00001006 1 00000204",
               b1.cmp_res, b1.PC_jump, b1.misalign, b1.PC_wb);
    end
    drain(3);
  endtask

  task automatic test_signed();
    drive_op(1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h40, 4'd3);
    tick();
    checks++;
    if (b1.cmp_res !== 1'b1) begin
      errors++;
      $display("FAIL signed_lt got=%b exp=1", b1.cmp_res);
    end
    drive_op(1'b0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h40, 4'd4);
    tick();
    checks++;
    if (b1.cmp_res !== 1'b0) begin
      errors++;
      $display("FAIL unsigned_lt got=%b exp=0", b1.cmp_res);
    end
    drain(4);
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen[$];
    int max_inf = 0;
    for (int k = 0; k < 9; k++) begin
      if (k < 4) drive_op(1'b0, 3'b001, 32'd1, 32'd2, 32'h10 * k, 32'h1000, 4'(k + 1));
      else       set_idle();
      tick();
      if (b3.finish) seen.push_back(b3.tag_out);
      if (int'(b3.inflight) > max_inf) max_inf = int'(b3.inflight);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL b2b lat%0d cyc%0d got=%h exp=%h", d ? 3 : 1, cyc, obs_vec(d), exp_vec(d));
        end
      end
    end
    checks++;
    if (seen.size() != 4 || seen[0] !== 4'd1 || seen[1] !== 4'd2 || seen[2] !== 4'd3 || seen[3] !== 4'd4) begin
      errors++;
      $display("FAIL b2b_order got %0d finishes exp tags 1,2,3,4", seen.size());
    end
    checks++;
    if (max_inf != 3) begin
      errors++;
      $display("FAIL b2b_inflight_max got=%0d exp=3", max_inf);
    end
  endtask

  task automatic test_flush();
    logic [15:0] seen = '0;
    for (int k = 0; k < 9; k++) begin
      set_idle();
      if (k == 0) drive_op(1'b0, 3'b000, 32'd9, 32'd9, 32'h30, 32'h500, 4'd1);
      if (k == 1) drive_op(1'b0, 3'b000, 32'd9, 32'd8, 32'h30, 32'h504, 4'd2);
      if (k == 3) begin
        drive_op(1'b0, 3'b010, 32'd0, 32'd0, 32'h30, 32'h508, 4'd3);
        flush = 1'b1;
      end
      tick();
      if (b3.finish) seen[b3.tag_out] = 1'b1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL flush lat%0d cyc%0d got=%h exp=%h", d ? 3 : 1, cyc, obs_vec(d), exp_vec(d));
        end
      end
    end
    checks++;
    if (seen !== 16'h0002) begin
      errors++;
      $display("FAIL flush_tags seen=%h exp=0002", seen);
    end
    checks++;
    if (b3.inflight !== 2'd0) begin
      errors++;
      $display("FAIL flush_inflight got=%0d exp=0", b3.inflight);
    end
  endtask

  task automatic test_reset_mid();
    logic any_fin = 1'b0;
    drive_op(1'b0, 3'b000, 32'd1, 32'd1, 32'h8, 32'h700, 4'd5);
    tick();
    drive_op(1'b0, 3'b000, 32'd1, 32'd1, 32'h8, 32'h704, 4'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_idle();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_vec(1) !== {W{1'b0}}) begin
        errors++;
        $display("FAIL reset_mid_outputs cyc%0d got=%h exp=0", cyc, obs_vec(1));
      end
      if (b3.finish) any_fin = 1'b1;
      tick();
    end
    checks++;
    if (any_fin !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_finish got=1 exp=0");
    end
  endtask

`ifdef FU_BRANCH_PREDICT_CHECK_EN
  task automatic test_predict();
    drain(3);
    drive_op(1'b0, 3'b000, 32'd5, 32'd5, 32'h20, 32'h100, 4'd8);
    pt = 1'b1; ptgt = 32'h124;
    tick();
    checks++;
    if (b1.mispredict !== 1'b1) begin
      errors++;
      $display("FAIL predict_target got=%b exp=1", b1.mispredict);
    end
    drive_op(1'b0, 3'b000, 32'd5, 32'd6, 32'h20, 32'h100, 4'd9);
    pt = 1'b0; ptgt = 32'h0;
    tick();
    checks++;
    if (b1.mispredict !== 1'b0) begin
      errors++;
      $display("FAIL predict_not_taken got=%b exp=0", b1.mispredict);
    end
    drain(4);
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 39) == 0);
      drive_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
               $urandom, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) rs2 = rs1;
      en    = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 14) == 0);
`ifdef FU_BRANCH_PREDICT_CHECK_EN
      pt   = 1'($urandom_range(0, 1));
      ptgt = ($urandom_range(0, 1) == 0) ? ((jalr ? rs1 : pc) + imm) & 32'hFFFF_FFFE : $urandom;
`endif
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL random lat%0d cyc%0d got=%h exp=%h", d ? 3 : 1, cyc, obs_vec(d), exp_vec(d));
        end
      end
    end
    rst = 1'b0;
    drain(4);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    set_idle();
    rst = 1'b1;
    test_reset();
    test_beq();
    test_jalr();
    test_signed();
    test_back_to_back();
    test_flush();
    test_reset_mid();
`ifdef FU_BRANCH_PREDICT_CHECK_EN
    test_predict();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
